// File: rtl/idx_to_vec_expand.sv
// Pipelined index-to-vector expander: rebuilds a one-hot or thermometer mask
// word from a bit index, doubling the vector width once per stage, MSB first.
module idx_to_vec_expand #(
  parameter int IDX_W = 10,
  localparam int OUT_W = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_mode,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  // Stage k occupies bits [2^(k+1)-2 +: 2^(k+1)] of the flattened vectors.
  localparam int TOT_W = 2 * OUT_W - 2;

  logic [IDX_W-1:0] v;
  logic [IDX_W-1:0] rdy;
  logic [TOT_W-1:0] e_all;
  logic [TOT_W-1:0] m_all;
  logic [IDX_W-1:0] idx_all [IDX_W];
  logic [IDX_W-1:0] mode_all;

  genvar gi;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_stage
      localparam int W   = 2 << gi;
      localparam int OFF = W - 2;

      logic             v_reg;
      logic             v_up;
      logic             mode_reg;
      logic             mode_next;
      logic [W-1:0]     e_reg;
      logic [W-1:0]     e_next;
      logic [W-1:0]     m_reg;
      logic [W-1:0]     m_next;
      logic [IDX_W-1:0] idx_reg;
      logic [IDX_W-1:0] idx_next;

      // A stage can take a new item unless it and every stage after it are
      // full with the output stalled; equivalent to the ~v | rdy_next chain.
      assign rdy[gi] = out_ready | ~(&v[IDX_W-1:gi]);

      if (gi == 0) begin : g_load_in
        always_comb begin
          v_up      = in_valid;
          idx_next  = in_idx;
          mode_next = in_mode;
          e_next    = '0;
          m_next    = '0;
          if (!in_none) begin
            e_next = in_idx[IDX_W-1] ? 2'b10 : 2'b01;
            m_next = in_idx[IDX_W-1] ? 2'b10 : 2'b11;
          end
        end
      end else begin : g_load_prev
        localparam int PW   = W / 2;
        localparam int POFF = PW - 2;

        logic          b;
        logic [PW-1:0] e_prev;
        logic [PW-1:0] m_prev;

        assign b      = idx_all[gi-1][IDX_W-1-gi];
        assign e_prev = e_all[POFF +: PW];
        assign m_prev = m_all[POFF +: PW];

        // Each upstream bit splits into a low/high pair selected by the next
        // index bit; the mask keeps the upper half and drops the low half
        // only where the selected boundary falls inside this pair.
        always_comb begin
          v_up      = v[gi-1];
          idx_next  = idx_all[gi-1];
          mode_next = mode_all[gi-1];
          e_next    = '0;
          m_next    = '0;
          for (int j = 0; j < PW; j++) begin
            e_next[2*j+1] = e_prev[j] & b;
            e_next[2*j]   = e_prev[j] & ~b;
            m_next[2*j+1] = m_prev[j];
            m_next[2*j]   = m_prev[j] & ~(e_prev[j] & b);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_reg    <= 1'b0;
          e_reg    <= '0;
          m_reg    <= '0;
          idx_reg  <= '0;
          mode_reg <= 1'b0;
        end else if (rdy[gi]) begin
          v_reg <= v_up;
          if (v_up) begin
            e_reg    <= e_next;
            m_reg    <= m_next;
            idx_reg  <= idx_next;
            mode_reg <= mode_next;
          end
        end
      end

      assign v[gi]             = v_reg;
      assign e_all[OFF +: W]   = e_reg;
      assign m_all[OFF +: W]   = m_reg;
      assign idx_all[gi]       = idx_reg;
      assign mode_all[gi]      = mode_reg;
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = v[IDX_W-1];
  assign busy      = |v;
  assign out_idx   = idx_all[IDX_W-1];
  assign out_vec   = mode_all[IDX_W-1] ? m_all[TOT_W-1 -: OUT_W]
                                       : e_all[TOT_W-1 -: OUT_W];

endmodule

// File: tb/tb_idx_to_vec_expand.sv
// Scoreboard bench for idx_to_vec_expand: expectations are queued on accept
// and compared against a shift-based reference model when the output pops.
module tb_idx_to_vec_expand;

  localparam int IDX_W  = 10;
  localparam int OUT_W  = 1 << IDX_W;
  localparam int N_RAND = 10000;

  typedef struct {
    logic [IDX_W-1:0] idx;
    bit               mode;
    bit               none;
    int               t_in;
    bit               lat;
  } item_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_mode;
  logic             in_none;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;
  logic [IDX_W-1:0] out_idx;
  logic             busy;

  item_t sb[$];
  int    pop_cyc[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    lat_mode = 1'b0;

  idx_to_vec_expand #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_mode   (in_mode),
    .in_none   (in_none),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [OUT_W-1:0] got,
                          input logic [OUT_W-1:0] exp);
    int d;
    int base;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      d = 0;
      for (int i = OUT_W - 1; i >= 0; i--) if (got[i] !== exp[i]) d = i;
      base = d & ~63;
      $display("FAIL %s: got=%h required=%h (bits %0d..%0d) t=%0t", tag,
               64'(got >> base), 64'(exp >> base), base + 63, base, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] model(input item_t it);
    logic [OUT_W-1:0] one;
    one = 1;
    if (it.none) return '0;
    if (it.mode) return ~((one << it.idx) - one);
    return one << it.idx;
  endfunction

  function automatic int ffs(input logic [OUT_W-1:0] vec);
    int r;
    r = -1;
    for (int i = OUT_W - 1; i >= 0; i--) if (vec[i]) r = i;
    return r;
  endfunction

  // Monitor: push on accept, compare the head item whenever the output is valid.
  always @(negedge clk) begin
    item_t it;
    if (reset_n) begin
      if (in_valid && in_ready) begin
        it.idx  = in_idx;
        it.mode = in_mode;
        it.none = in_none;
        it.t_in = cyc;
        it.lat  = lat_mode;
        sb.push_back(it);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", out_valid, 1'b0);
        end else begin
          it = sb[0];
          check_eq("out_vec", out_vec, model(it));
          check_eq("out_idx", out_idx, it.idx);
          if (!it.mode && !it.none) check_eq("ffs_idx", ffs(out_vec), out_idx);
          if (out_ready) begin
            void'(sb.pop_front());
            pop_cyc.push_back(cyc);
            if (it.lat) check_eq("latency", cyc - it.t_in, IDX_W);
            $display("pop idx=%0d mode=%0d none=%0d cyc=%0d", it.idx, it.mode, it.none, cyc);
          end
        end
      end
    end
  end

  // Entered and left at posedge+1; holds in_valid until the item is taken.
  task automatic push(input int idx, input bit mode, input bit none);
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_idx   = IDX_W'(idx);
    in_mode  = mode;
    in_none  = none;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check_eq("push_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check_eq("drain_left", sb.size(), 0);
    check_eq("drain_busy", busy, 1'b0);
  endtask

  initial begin
    int acc;
    int n;
    bit took;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_mode   = 1'b0;
    in_none   = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_vec", out_vec, '0);
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // One-hot streaming with latency and back-to-back output checks.
    lat_mode = 1'b1;
    pop_cyc.delete();
    push(0, 0, 0);
    push(1, 0, 0);
    push(511, 0, 0);
    push(512, 0, 0);
    push(1023, 0, 0);
    drain();
    lat_mode = 1'b0;
    check_eq("onehot_pops", pop_cyc.size(), 5);
    if (pop_cyc.size() == 5) check_eq("onehot_consec", pop_cyc[4] - pop_cyc[0], 4);

    // Mask mode and the "none" flag in both modes.
    push(0, 1, 0);
    push(3, 1, 0);
    push(1023, 1, 0);
    push(5, 1, 1);
    push(7, 0, 1);
    drain();

    // Backpressure: 20 stalled cycles while offering 15 items.
    out_ready = 1'b0;
    acc = 0;
    pop_cyc.delete();
    for (int c = 0; c < 20; c++) begin
      in_valid = (acc < 15);
      in_idx   = IDX_W'(acc * 67 + 2);
      in_mode  = acc[0];
      in_none  = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("bp_accepts", acc, 10);
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = acc; i < 15; i++) push(i * 67 + 2, i[0], 0);
    drain();
    check_eq("bp_delivered", pop_cyc.size(), 15);

    // Bubble collapse: second item closes up behind the stalled head.
    pop_cyc.delete();
    push(100, 0, 0);
    idle(4);
    push(200, 1, 0);
    idle(3);
    out_ready = 1'b0;
    idle(15);
    check_eq("bub_out_valid", out_valid, 1'b1);
    check_eq("bub_out_idx", out_idx, 10'd100);
    check_eq("bub_in_ready", in_ready, 1'b1);
    check_eq("bub_busy", busy, 1'b1);
    out_ready = 1'b1;
    drain();
    check_eq("bub_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) check_eq("bub_adjacent", pop_cyc[1] - pop_cyc[0], 1);

    // Reset with five items in flight.
    for (int i = 0; i < 5; i++) push(i * 100 + 9, i[0], 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    idle(2);
    reset_n = 1'b1;
    idle(20);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_out_vec", out_vec, '0);

    // Random traffic with random backpressure.
    n = 0;
    while (n < N_RAND) begin
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        in_idx   = IDX_W'($urandom);
        in_mode  = 1'($urandom);
        in_none  = ($urandom_range(0, 15) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        n++;
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
